qpmm_iter: RTL

Iterative, runtime-modulus Montgomery multiplier: the parametrised successor to the fixed-modulus, fully pipelined BN254 QPMM datapath. It computes Z ≡ A·B·R⁻¹ (mod M) one D-bit digit per cycle, with R = 2^(D·K), behind valid/ready handshakes. It targets area-constrained pairing/ECC controllers that need many curves or moduli, not one multiply per cycle.

---
 rtl/qpmm_iter_pkg.sv | 38 +++
 rtl/qpmm_digit_pe.sv | 35 +++
 rtl/qpmm_iter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/qpmm_iter_pkg.sv
// Shared definitions for the iterative Montgomery multiplier: digit-count
// helper, FSM state encoding and BN254 reference constants.
package qpmm_iter_pkg;

    // Number of D-bit digits needed so that R = 2^(D*K) satisfies 4M < R.
    function automatic int qpmm_calc_k(input int n_bits, input int d);
        return (n_bits + 2 + d - 1) / d;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // BN254 base-field modulus and -M^-1 mod 2^16.
    localparam logic [255:0] BN254_M =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam logic [15:0]  BN254_M_PRIME_D16 = 16'h6389;
    // R exponent for the default geometry (D=16, K=17).
    localparam int           BN254_R_EXP = 272;

    // 2^e mod BN254_M by repeated doubling; evaluated at elaboration time.
    function automatic logic [255:0] bn254_pow2_mod(input int e);
        logic [256:0] r;
        r = 257'd1;
        for (int i = 0; i < e; i++) begin
            r = r << 1;
            if (r >= {1'b0, BN254_M}) r = r - {1'b0, BN254_M};
        end
        return r[255:0];
    endfunction

    localparam logic [255:0] BN254_R_MOD  = bn254_pow2_mod(BN254_R_EXP);
    localparam logic [255:0] BN254_R2_MOD = bn254_pow2_mod(2 * BN254_R_EXP);

endpackage

// File: rtl/qpmm_digit_pe.sv
// One radix-2^D Montgomery step, purely combinational:
//   T = Z + a*B ; q = T*M' mod 2^D ; Z' = (T + q*M) >> D
module qpmm_digit_pe #(
    parameter int W = 272,
    parameter int D = 16
) (
    input  logic [W:0]   z_i,
    input  logic [D-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] m_i,
    input  logic [D-1:0] m_prime_i,
    output logic [W:0]   z_o
);

    // Wide enough for T + q*M with Z < 2M, B < 2M, 4M < 2^W.
    localparam int TW = W + D + 2;

    logic [TW-1:0] t;
    logic [TW-1:0] u;
    logic [D-1:0]  q;
    logic [D-1:0]  unused_low;
    logic          unused_top;

    // Accumulate one digit product, pick q so the low digit cancels, shift it out.
    always_comb begin
        t          = TW'(z_i) + TW'(a_i) * TW'(b_i);
        q          = t[D-1:0] * m_prime_i;
        u          = t + TW'(q) * TW'(m_i);
        z_o        = u[W+D:D];
        // Low digit is zero by construction; top bit is zero since Z' < 2M.
        unused_low = u[D-1:0];
        unused_top = u[TW-1];
    end

endmodule

// File: rtl/qpmm_iter.sv
// Iterative runtime-modulus Montgomery multiplier, Z = A*B*R^-1 mod M with
// R = 2^(D*K), one digit per cycle behind valid/ready handshakes.
// Optional build macro QPMM_ITER_FINAL_SUB_EN adds a final conditional
// subtraction state so out_z is fully reduced to [0, M).
module qpmm_iter
    import qpmm_iter_pkg::*;
#(
    parameter  int N_BITS = 256,
    parameter  int D      = 16,
    localparam int K      = qpmm_calc_k(N_BITS, D),
    localparam int W      = D * K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [N_BITS-1:0] in_m,
    input  logic [D-1:0]      in_m_prime,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_z
);

    localparam int            CW   = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    z_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  m_q;
    logic [D-1:0]  mp_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  out_z_q;
    logic [W:0]    z_step_d;
    logic          accept;

    assign accept = (state_q == S_IDLE) && in_valid;

    qpmm_digit_pe #(
        .W (W),
        .D (D)
    ) u_pe (
        .z_i       (z_q),
        .a_i       (a_q[D-1:0]),
        .b_i       (b_q),
        .m_i       (m_q),
        .m_prime_i (mp_q),
        .z_o       (z_step_d)
    );

`ifdef QPMM_ITER_FINAL_SUB_EN
    logic [W:0] z_sub_d;

    // Bring the redundant result [0, 2M) into [0, M).
    always_comb begin
        z_sub_d = z_q;
        if (z_q >= {1'b0, m_q}) z_sub_d = z_q - {1'b0, m_q};
    end
`endif

    // Operand capture on accept; multiplicand shifts so its low digit is a_i.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            m_q  <= W'(in_m);
            mp_q <= in_m_prime;
        end else if (state_q == S_RUN) begin
            a_q  <= a_q >> D;
        end
    end

    // Control FSM with registered handshake outputs and the Z accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            z_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        z_q        <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    z_q   <= z_step_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
`ifdef QPMM_ITER_FINAL_SUB_EN
                        state_q <= S_SUB;
`else
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_z_q     <= z_step_d[W-1:0];
`endif
                    end
                end
`ifdef QPMM_ITER_FINAL_SUB_EN
                S_SUB: begin
                    z_q         <= z_sub_d;
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                    out_z_q     <= z_sub_d[W-1:0];
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;

endmodule
